// File: rtl/bus_target_responder_if.sv
// Core-side bus bundle for bus_target_responder: word address, write data,
// level read/write requests and the read data returned to the core.
interface bus_target_responder_if;
  logic [15:0] ABUS;
  logic [15:0] DIN;
  logic        RD;
  logic        WR;
  logic [15:0] DOUT;

  modport master (output ABUS, DIN, RD, WR, input DOUT);
  modport slave  (input ABUS, DIN, RD, WR, output DOUT);
endinterface

// File: rtl/bus_target_responder.sv
// Bus target: word RAM plus an IO page (GPIO, tick counter, W1C status), 1-cycle reads,
// one commit per WR assertion. Define BUS_TARGET_WPROT_EN to write-protect the low PROT_WORDS.
module bus_target_responder #(
  parameter int unsigned MEM_AW     = 12,
  parameter logic [15:0] IO_BASE    = 16'hFF00,
  parameter int unsigned GPIO_W     = 8,
  parameter int unsigned PROT_WORDS = 256
) (
  input  logic                   CLK,
  input  logic                   RESET,
  bus_target_responder_if.slave  bus,
  input  logic [GPIO_W-1:0]      GPIO_IN,
  output logic [GPIO_W-1:0]      GPIO_OUT,
  output logic                   BUS_ERR
);

`ifdef BUS_TARGET_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  typedef enum logic {IDLE = 1'b0, WHOLD = 1'b1} state_e;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } bus_req_t;

  logic [15:0] mem [2**MEM_AW];

  state_e                       state_q, state_d;
  logic [15:0]                  dout_q, dout_d;
  logic [GPIO_W-1:0]            gpio_out_q, gpio_out_d;
  logic [1:0][GPIO_W-1:0]       gpio_sync_q, gpio_sync_d;
  logic [15:0]                  tick_q, tick_d;
  logic [2:0]                   status_q, status_d;

  bus_req_t          req;
  logic              is_ram, is_io, prot_hit;
  logic [7:0]        io_off;
  logic [MEM_AW-1:0] ram_idx;
  logic              collide, wr_go, rd_go, ram_we;
  logic [15:0]       rdata;
  logic [2:0]        st_set, st_clr;

  always_comb begin
    req      = '{rd: bus.RD, wr: bus.WR, addr: bus.ABUS, data: bus.DIN};
    is_ram   = (req.addr >> MEM_AW) == 16'd0;
    is_io    = !is_ram && (req.addr[15:8] == IO_BASE[15:8]);
    io_off   = req.addr[7:0];
    ram_idx  = req.addr[MEM_AW-1:0];
    prot_hit = WPROT && is_ram && (32'(req.addr) < PROT_WORDS);
    // Only IDLE arbitrates RD against WR; in WHOLD the write is already done.
    collide  = (state_q == IDLE) && req.rd && req.wr;
    wr_go    = (state_q == IDLE) && req.wr && !req.rd;
    rd_go    = req.rd && !collide;
  end

  always_comb begin
    rdata = '0;
    if (is_ram) begin
      rdata = mem[ram_idx];
    end else if (is_io) begin
      case (io_off)
        8'h00:   rdata[GPIO_W-1:0] = gpio_out_q;
        8'h01:   rdata[GPIO_W-1:0] = gpio_sync_q[1];
        8'h02:   rdata             = tick_q;
        8'h03:   rdata[2:0]        = status_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    dout_d         = dout_q;
    gpio_out_d     = gpio_out_q;
    tick_d         = tick_q + 16'd1;
    gpio_sync_d[0] = GPIO_IN;
    gpio_sync_d[1] = gpio_sync_q[0];
    ram_we         = 1'b0;
    st_set         = '0;
    st_clr         = '0;

    case (state_q)
      IDLE:    if (wr_go) state_d = WHOLD;
      WHOLD:   if (!req.wr) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (rd_go)   dout_d = rdata;
    if (collide) st_set[0] = 1'b1;

    if (wr_go) begin
      if (is_ram) begin
        if (prot_hit) st_set[2] = 1'b1;
        else          ram_we    = 1'b1;
      end else if (is_io) begin
        case (io_off)
          8'h00:   gpio_out_d = req.data[GPIO_W-1:0];
          8'h03:   st_clr     = req.data[2:0];
          default: ;
        endcase
      end else begin
        st_set[1] = 1'b1;
      end
    end

    // A new error on a bit beats a clear of the same bit.
    status_d = (status_q & ~st_clr) | st_set;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= IDLE;
      dout_q      <= '0;
      gpio_out_q  <= '0;
      gpio_sync_q <= '0;
      tick_q      <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      dout_q      <= dout_d;
      gpio_out_q  <= gpio_out_d;
      gpio_sync_q <= gpio_sync_d;
      tick_q      <= tick_d;
      status_q    <= status_d;
    end
  end

  // RAM keeps its contents through reset, but a write seen at a reset edge is dropped.
  always_ff @(posedge CLK) begin
    if (RESET && ram_we) mem[ram_idx] <= req.data;
  end

  assign bus.DOUT = dout_q;
  assign GPIO_OUT = gpio_out_q;
  assign BUS_ERR  = |status_q;

endmodule
